// File: rtl/ref_sample_fetcher.sv
// ref_sample_fetcher
//   Fetches the 9x9 integer reference window for one 4x4 block from the
//   reference-frame memory and hands it to the interpolator one 9-sample line
//   at a time. Window origin = block position + integer MV - 2 (6-tap support).
//   Out-of-frame coordinates are clamped to the nearest edge sample.
//
// Ports
//   clk, reset_all              : clock, synchronous active-high reset
//   start                       : one-cycle request, sampled only when idle
//   coord_x, coord_y            : block top-left position (unsigned)
//   mv_x_integer, mv_y_integer  : integer motion vector (signed)
//   mem_rd, mem_addr, mem_rdata : reference memory read port (1-cycle latency)
//   line_valid, line_ready      : line handshake towards the interpolator
//   integer_samples             : 9 samples, sample k at [8k+7:8k]
//   line_idx                    : line being fetched / presented (0..8)
//   busy, done                  : activity flag, end-of-window pulse
module ref_sample_fetcher #(
  parameter int unsigned FRAME_W   = 64,
  parameter int unsigned FRAME_H   = 64,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 reset_all,
  input  logic                 start,
  input  logic [7:0]           coord_x,
  input  logic [7:0]           coord_y,
  input  logic [14:0]          mv_x_integer,
  input  logic [14:0]          mv_y_integer,
  output logic                 mem_rd,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic [71:0]          integer_samples,
  output logic [3:0]           line_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned XW   = $clog2(FRAME_W);
  localparam logic [17:0] XMax = 18'(FRAME_W - 1);
  localparam logic [17:0] YMax = 18'(FRAME_H - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StFin} state_e;

  state_e state_q, state_d;

  logic [16:0] x0_q, y0_q;       // window origin, two's complement
  logic [3:0]  rd_cnt_q;         // reads issued for the current line
  logic [3:0]  cap_cnt_q;        // bytes captured for the current line
  logic        rd_pend_q;        // a read was issued last cycle; data is on mem_rdata
  logic [3:0]  line_idx_q;
  logic [71:0] samples_q;

  logic [16:0]          origin_x, origin_y;
  logic [17:0]          xs, ys;
  logic [ADDR_BITS-1:0] xs_c, ys_c;

  assign origin_x = 17'(coord_x) + {{2{mv_x_integer[14]}}, mv_x_integer} - 17'd2;
  assign origin_y = 17'(coord_y) + {{2{mv_y_integer[14]}}, mv_y_integer} - 17'd2;

  // Sign-extend to 18 bits so origin + offset cannot overflow.
  assign xs = {x0_q[16], x0_q} + {14'd0, rd_cnt_q};
  assign ys = {y0_q[16], y0_q} + {14'd0, line_idx_q};

  // Edge padding: clamp each coordinate into the frame.
  always_comb begin
    xs_c = '0;
    ys_c = '0;
    if (xs[17])          xs_c = '0;
    else if (xs > XMax)  xs_c = ADDR_BITS'(FRAME_W - 1);
    else                 xs_c = ADDR_BITS'(xs);
    if (ys[17])          ys_c = '0;
    else if (ys > YMax)  ys_c = ADDR_BITS'(FRAME_H - 1);
    else                 ys_c = ADDR_BITS'(ys);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset_all) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFetch;
      StFetch:   if (rd_pend_q && cap_cnt_q == 4'd8) state_d = StPresent;
      StPresent: if (line_ready) state_d = (line_idx_q < 4'd8) ? StFetch : StFin;
      StFin:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    mem_rd          = (state_q == StFetch) && (rd_cnt_q < 4'd9);
    mem_addr        = mem_rd ? ((ys_c << XW) | xs_c) : '0;
    line_valid      = (state_q == StPresent);
    busy            = (state_q != StIdle);
    done            = (state_q == StFin);
    line_idx        = line_idx_q;
    integer_samples = samples_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset_all) begin
      x0_q       <= '0;
      y0_q       <= '0;
      rd_cnt_q   <= '0;
      cap_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      line_idx_q <= '0;
      samples_q  <= '0;
    end else begin
      // Pending flag doubles as the capture strobe; reset clears it so any
      // in-flight byte is dropped.
      rd_pend_q <= mem_rd;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x0_q       <= origin_x;
            y0_q       <= origin_y;
            line_idx_q <= '0;
            rd_cnt_q   <= '0;
            cap_cnt_q  <= '0;
          end
        end
        StFetch: begin
          if (rd_cnt_q < 4'd9) rd_cnt_q <= rd_cnt_q + 4'd1;
          if (rd_pend_q) begin
            // Shift right so the first byte ends up at [7:0].
            samples_q <= {mem_rdata, samples_q[71:8]};
            cap_cnt_q <= cap_cnt_q + 4'd1;
          end
        end
        StPresent: begin
          if (line_ready && line_idx_q < 4'd8) begin
            line_idx_q <= line_idx_q + 4'd1;
            rd_cnt_q   <= '0;
            cap_cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
